// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage posit field decoder with valid/ready handshake
// S1 takes the magnitude of the word; S2 splits it into regime, exponent and fraction.
module posit_decode_pipe #(
    parameter int N  = 64,
    parameter int ES = 4,
    parameter int FW = N - 3 - ES,
    parameter int KW = $clog2(N) + 1,
    parameter int EW = (ES > 0) ? ES : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_posit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic          out_zero,
    output logic          out_nar,
    output logic [KW-1:0] out_k,
    output logic [EW-1:0] out_exp,
    output logic [FW-1:0] out_frac,
    output logic [KW-2:0] out_rlen
);

    localparam logic [N-2:0]  U_ONE = {{(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0]  NAR_W = {1'b1, {(N-1){1'b0}}};
    localparam logic [KW-2:0] M_ONE = {{(KW-2){1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_ZERO = '0;

    logic          s1_valid_q, s1_valid_d;
    logic [N-2:0]  u_q, u_d;
    logic          s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d;
    logic          s1_nar_q, s1_nar_d;

    logic          out_valid_q, out_valid_d;
    logic          sign_q, sign_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;
    logic [KW-1:0] k_q, k_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [FW-1:0] frac_q, frac_d;
    logic [KW-2:0] rlen_q, rlen_d;

    logic          s1_adv, s2_adv;

    logic          r0;
    logic          run;
    logic [KW-2:0] m;
    logic [KW-1:0] k_dec;
    logic [N-4:0]  ef;
    logic [EW-1:0] exp_dec;
    logic [FW-1:0] frac_dec;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = rst_n & s1_adv;

    // Leading-digit detector: m counts the run of bits equal to the first regime bit.
    always_comb begin
        r0  = u_q[N-2];
        m   = '0;
        run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (u_q[i] == r0)) begin
                m = m + M_ONE;
            end else begin
                run = 1'b0;
            end
        end
        k_dec = r0 ? ({1'b0, m} - K_ONE) : (K_ZERO - {1'b0, m});
        // Drop regime run and terminator (m+1 bits); the top two bits always belong to them.
        ef = u_q[N-4:0] << (m - M_ONE);
    end

    generate
        if (ES > 0) begin : g_exp
            assign exp_dec = ef[N-4 -: EW];
        end else begin : g_noexp
            assign exp_dec = '0;
        end
    endgenerate

    assign frac_dec = ef[FW-1:0];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        u_d         = u_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_nar_d    = s1_nar_q;
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        nar_d       = nar_q;
        k_d         = k_q;
        exp_d       = exp_q;
        frac_d      = frac_q;
        rlen_d      = rlen_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_posit[N-1];
                u_d       = in_posit[N-1] ? (~in_posit[N-2:0] + U_ONE) : in_posit[N-2:0];
                s1_zero_d = (in_posit == '0);
                s1_nar_d  = (in_posit == NAR_W);
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                zero_d = s1_zero_q;
                nar_d  = s1_nar_q;
                if (s1_zero_q || s1_nar_q) begin
                    sign_d = s1_nar_q;
                    k_d    = '0;
                    exp_d  = '0;
                    frac_d = '0;
                    rlen_d = '0;
                end else begin
                    sign_d = s1_sign_q;
                    k_d    = k_dec;
                    exp_d  = exp_dec;
                    frac_d = frac_dec;
                    rlen_d = m;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            u_q         <= '0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            nar_q       <= 1'b0;
            k_q         <= '0;
            exp_q       <= '0;
            frac_q      <= '0;
            rlen_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            u_q         <= u_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            nar_q       <= nar_d;
            k_q         <= k_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            rlen_q      <= rlen_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = sign_q;
    assign out_zero  = zero_q;
    assign out_nar   = nar_q;
    assign out_k     = k_q;
    assign out_exp   = exp_q;
    assign out_frac  = frac_q;
    assign out_rlen  = rlen_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - directed vector bench for posit_decode_pipe at N=8, ES=1
module tb_posit_decode_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_posit;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign, out_zero, out_nar;
    logic [3:0] out_k;
    logic [0:0] out_exp;
    logic [3:0] out_frac;
    logic [2:0] out_rlen;

    int total = 0;
    int bad   = 0;

    posit_decode_pipe #(.N(8), .ES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
        .out_k(out_k), .out_exp(out_exp), .out_frac(out_frac), .out_rlen(out_rlen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  p;
        logic [14:0] fields;
    } vec_t;

    vec_t vec[13];

    function automatic logic [14:0] mk(input logic s, input logic z, input logic n,
                                       input logic [3:0] k, input logic e,
                                       input logic [3:0] f, input logic [2:0] r);
        return {s, z, n, k, e, f, r};
    endfunction

    function automatic logic [14:0] got();
        return {out_sign, out_zero, out_nar, out_k, out_exp, out_frac, out_rlen};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send_one(input logic [7:0] p);
        in_valid = 1'b1;
        in_posit = p;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bp_w[3];
        logic       acc;

        vec[0]  = '{8'h40, mk(0, 0, 0, 4'h0, 1'b0, 4'h0, 3'd1)};
        vec[1]  = '{8'h5A, mk(0, 0, 0, 4'h0, 1'b1, 4'hA, 3'd1)};
        vec[2]  = '{8'hC0, mk(1, 0, 0, 4'h0, 1'b0, 4'h0, 3'd1)};
        vec[3]  = '{8'h7F, mk(0, 0, 0, 4'h6, 1'b0, 4'h0, 3'd7)};
        vec[4]  = '{8'h01, mk(0, 0, 0, 4'hA, 1'b0, 4'h0, 3'd6)};
        vec[5]  = '{8'h00, mk(0, 1, 0, 4'h0, 1'b0, 4'h0, 3'd0)};
        vec[6]  = '{8'h80, mk(1, 0, 1, 4'h0, 1'b0, 4'h0, 3'd0)};
        vec[7]  = '{8'h30, mk(0, 0, 0, 4'hF, 1'b1, 4'h0, 3'd1)};
        vec[8]  = '{8'hFF, mk(1, 0, 0, 4'hA, 1'b0, 4'h0, 3'd6)};
        vec[9]  = '{8'h7E, mk(0, 0, 0, 4'h5, 1'b0, 4'h0, 3'd6)};
        vec[10] = '{8'h6D, mk(0, 0, 0, 4'h1, 1'b1, 4'hA, 3'd2)};
        vec[11] = '{8'h93, mk(1, 0, 0, 4'h1, 1'b1, 4'hA, 3'd2)};
        vec[12] = '{8'h08, mk(0, 0, 0, 4'hD, 1'b0, 4'h0, 3'd3)};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_posit  = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_fields", {17'd0, got()}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // One word at a time: out_valid must rise exactly two cycles after acceptance.
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("single_acc_%0d", i), {31'd0, in_ready}, 32'd1);
            send_one(vec[i].p);
            chk($sformatf("single_lat1_%0d", i), {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("single_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("single_fields_%02h", vec[i].p), {17'd0, got()}, {17'd0, vec[i].fields});
            @(negedge clk);
        end

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 15; i++) begin
            if (i >= 2) begin
                chk($sformatf("stream_valid_%0d", i - 2), {31'd0, out_valid}, 32'd1);
                chk($sformatf("stream_fields_%0d", i - 2), {17'd0, got()}, {17'd0, vec[i-2].fields});
            end
            if (i < 13) begin
                chk($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'd1);
                in_valid = 1'b1;
                in_posit = vec[i].p;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: three words offered, only two fit.
        bp_w[0] = 8'h40;
        bp_w[1] = 8'h5A;
        bp_w[2] = 8'h6D;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_posit = bp_w[i];
            acc = in_ready;
            chk($sformatf("bp_accept_%0d", i), {31'd0, acc}, (i < 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_fields", {17'd0, got()}, {17'd0, vec[0].fields});
        chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_out_0", {17'd0, got()}, {17'd0, vec[0].fields});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid_1", {31'd0, out_valid}, 32'd1);
        chk("bp_out_1", {17'd0, got()}, {17'd0, vec[1].fields});
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_2", {31'd0, out_valid}, 32'd1);
        chk("bp_out_2", {17'd0, got()}, {17'd0, vec[10].fields});
        @(posedge clk);
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full discards the words in flight.
        out_ready = 1'b0;
        send_one(8'h7F);
        send_one(8'h01);
        chk("rst_full_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fields", {17'd0, got()}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_rel_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_%0d", i), {31'd0, out_valid}, 32'd0);
        end
        send_one(8'h5A);
        chk("rst_next_lat1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_next_valid", {31'd0, out_valid}, 32'd1);
        chk("rst_next_fields", {17'd0, got()}, {17'd0, vec[1].fields});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posit_decode_pipe.md
POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 Parameter N, default 64, posit word width; legal range 8..64.
REQ-002 Parameter ES, default 4, exponent field width; legal range 0..N-5.
REQ-003 Derived widths: FW = N-3-ES (fraction, hidden bit excluded); KW = clog2(N)+1 (signed regime value).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_posit holds a word to decode.
REQ-007 in_ready  output  1  block accepts in_posit this cycle.
REQ-008 in_posit  input  N  raw posit word.
REQ-009 out_valid  output  1  decoded fields valid.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.
REQ-011 out_sign, out_zero, out_nar  output  1 each  sign, zero flag, NaR flag.
REQ-012 out_k  output  KW  signed regime value, two's complement.
REQ-013 out_exp  output  ES  exponent field (absent when ES=0).
REQ-014 out_frac  output  FW  fraction, MSB-aligned, zero-padded on the right.
REQ-015 out_rlen  output  KW-1  regime run length m, unsigned.

Function
REQ-016 Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
REQ-017 Two register stages, S1 and S2; latency exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-018 Throughput one word per cycle when out_ready stays high.
REQ-019 S2 advances when ~out_valid | out_ready; S1 advances when ~s1_valid | S2 advances; in_ready = S1 advances, no combinational path from in_valid to in_ready.
REQ-020 Under backpressure both stages hold; order preserved; no word dropped or duplicated.
REQ-021 S1: sign = p[N-1]; u = sign ? two's-complement(p) : p; zero = (p == 0); nar = (p == 1 followed by N-1 zeros); register u[N-2:0], sign, zero, nar.
REQ-022 S2: parametrised leading-digit detector on u[N-2:0]; r0 = u[N-2]; m = count of leading bits equal to r0, 1..N-1.
REQ-023 k = r0 ? m-1 : -m.
REQ-024 Terminating bit skipped; next ES bits form out_exp, next FW bits form out_frac; bits beyond the word end read as 0.
REQ-025 m = N-1 (no terminating bit, run reaches bit 0): out_exp = 0 and out_frac = 0.
REQ-026 out_zero or out_nar set: out_sign, out_k, out_exp, out_frac, out_rlen all 0, except out_sign = 1 for NaR.
REQ-027 Output fields change only when S2 loads; stable while out_valid & ~out_ready.

Reset
REQ-028 rst_n low immediately clears S1/S2 valid bits; out_valid = 0 and all out_* = 0 while rst_n is low.
REQ-029 in_ready = 0 while rst_n is low; in_ready = 1 in the first cycle after release.
REQ-030 Words in flight at reset are discarded; none emerges after release.

Verification (N=8, ES=1, FW=4, out_ready=1 unless stated)
REQ-031 0x40 -> after 2 cycles: sign 0, k 0, rlen 1, exp 0, frac 0000.
REQ-032 0x5A -> k 0, exp 1, frac 1010; 0xC0 -> sign 1, k 0, exp 0, frac 0000.
REQ-033 0x7F -> k 6, rlen 7, exp 0, frac 0; 0x01 -> k -6, rlen 6, exp 0, frac 0.
REQ-034 0x00 -> zero 1, other fields 0; 0x80 -> nar 1, sign 1, other fields 0.
REQ-035 out_ready low, 3 words offered back-to-back -> 2 accepted, then in_ready 0; out_ready high -> all 3 emerge in order, one per cycle.
REQ-036 rst_n pulsed low with both stages full -> out_valid 0 the same cycle; no stale output after release; next word appears 2 cycles after acceptance.
